child_sequencer: RTL and testbench

- Sequencer for a five-instance child group (inst_0..inst_4 in a generated hierarchy level).
- On a start request, launches each enabled child in ascending index order, one at a time.
- For each child: issues a one-cycle start pulse, then waits for that child's done before moving on.
- Sits in the parent module alongside the children; gives the parent one start/done handshake for the whole group.

---
 rtl/child_seq_pkg.sv | 9 +
 rtl/lowest_set_idx.sv | 15 +
 rtl/child_sequencer.sv | 111 +++++++++++
 tb/tb_child_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/child_seq_pkg.sv
// child_seq_pkg: shared state encoding, default sizes and index-width helper for child_sequencer.
package child_seq_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, LAUNCH, WAIT, FINISH} state_e;
  localparam int NUM_CHILD_DEF = 5;
  localparam int TIMEOUT_CYC_DEF = 200;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lowest_set_idx.sv
// lowest_set_idx: combinational priority encoder, index of the lowest set bit plus a valid flag.
module lowest_set_idx #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) idx_o = vec_i[i] ? W'(i) : idx_o;
  end
  assign valid_o = |vec_i;
endmodule

// File: rtl/child_sequencer.sv
// child_sequencer: launches each enabled child in ascending order and waits for its done.
// Define CHILD_SEQ_TIMEOUT_EN to add a per-child watchdog with err/fail reporting.
module child_sequencer
  import child_seq_pkg::*;
#(
  parameter int NUM_CHILD   = NUM_CHILD_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int IDX_W       = idx_w(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NUM_CHILD-1:0] mask_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [NUM_CHILD-1:0] fail_mask_o,
  output logic [IDX_W-1:0]     cur_idx_o,
  output logic [NUM_CHILD-1:0] child_start_o,
  input  logic [NUM_CHILD-1:0] child_done_i
);
  if (NUM_CHILD < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("child_sequencer: NUM_CHILD and TIMEOUT_CYC must both be >= 2");
  end
  state_e               state_q;
  logic [NUM_CHILD-1:0] pend_q, start_q;
  logic [IDX_W-1:0]     idx_q, low_idx;
  logic                 busy_q, done_q, low_vld, hit;
  lowest_set_idx #(.N(NUM_CHILD), .W(IDX_W)) u_lsi (
    .vec_i  (pend_q),
    .idx_o  (low_idx),
    .valid_o(low_vld)
  );
  assign hit = child_done_i[idx_q];
`ifdef CHILD_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]        wdog_q;
  logic                 err_q;
  logic [NUM_CHILD-1:0] fail_q;
  assign err_o       = err_q;
  assign fail_mask_o = fail_q;
`else
  assign err_o       = 1'b0;
  assign fail_mask_o = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      start_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CHILD_SEQ_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
      fail_q  <= '0;
`endif
    end else begin
      start_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          pend_q  <= mask_i;
          busy_q  <= 1'b1;
          state_q <= SCAN;
`ifdef CHILD_SEQ_TIMEOUT_EN
          err_q   <= 1'b0;
          fail_q  <= '0;
`endif
        end
        SCAN: if (low_vld) begin
          idx_q   <= low_idx;
          start_q <= NUM_CHILD'(1) << low_idx;
          state_q <= LAUNCH;
        end else begin
          done_q  <= 1'b1;
          state_q <= FINISH;
        end
        LAUNCH: begin
`ifdef CHILD_SEQ_TIMEOUT_EN
          wdog_q  <= '0;
`endif
          state_q <= WAIT;
        end
        // done wins over a watchdog expiry in the same cycle
        WAIT: if (hit) begin
          pend_q[idx_q] <= 1'b0;
          state_q       <= SCAN;
        end
`ifdef CHILD_SEQ_TIMEOUT_EN
        else if (wdog_q == CW'(TIMEOUT_CYC - 1)) begin
          pend_q[idx_q] <= 1'b0;
          fail_q[idx_q] <= 1'b1;
          err_q         <= 1'b1;
          state_q       <= SCAN;
        end else wdog_q <= wdog_q + 1'b1;
`endif
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cur_idx_o     = idx_q;
  assign child_start_o = start_q;
endmodule

// File: tb/tb_child_sequencer.sv
// tb_child_sequencer: randomized self-checking bench; expected schedule derived from per-child latencies.
module tb_child_sequencer;
  import child_seq_pkg::*;
  localparam int NC = NUM_CHILD_DEF;
  localparam int TO = TIMEOUT_CYC_DEF;
  localparam int IW = idx_w(NC);
  logic          clk = 1'b0, rst = 1'b1, start_i = 1'b0;
  logic [NC-1:0] mask_i = '0, done_mdl = '0, noise = '0;
  logic [NC-1:0] child_start_o, child_done_i, fail_mask_o;
  logic          busy_o, done_o, err_o;
  logic [IW-1:0] cur_idx_o;
  int errors = 0, checks = 0;
  int lat[NC];
  int rem[NC];
  always #5 clk = ~clk;
  assign child_done_i = done_mdl | noise;
  child_sequencer #(.NUM_CHILD(NC), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mask_i       (mask_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .fail_mask_o  (fail_mask_o),
    .cur_idx_o    (cur_idx_o),
    .child_start_o(child_start_o),
    .child_done_i (child_done_i)
  );
  // child k pulses done lat[k] cycles after its start pulse; lat 0 never answers
  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      done_mdl[k] = 1'b0;
      if (rst) rem[k] = 0;
      else if (child_start_o[k]) rem[k] = lat[k];
      else if (rem[k] > 0) begin
        rem[k] = rem[k] - 1;
        done_mdl[k] = (rem[k] == 0);
      end
    end
  end
  task automatic set_lat(input int v);
    for (int k = 0; k < NC; k++) lat[k] = v;
  endtask
  task automatic run_seq(input logic [NC-1:0] m, input bit noisy);
    int launch[NC];
    int t, fin, last_k;
    logic [NC-1:0] exp_fail, exp_start;
    t = 2;
    last_k = -1;
    exp_fail = '0;
    for (int k = 0; k < NC; k++) begin
      launch[k] = -1;
      if (m[k]) begin
        launch[k] = t;
        last_k = k;
        if (lat[k] == 0) exp_fail[k] = 1'b1;
        t = t + ((lat[k] != 0) ? lat[k] : TO) + 2;
      end
    end
    fin = t;
    @(negedge clk);
    start_i = 1'b1;
    mask_i = m;
    checks++;
    if (busy_o !== 1'b0) $display("FAIL busy_before_start got=%b exp=0", busy_o);
    for (int c = 1; c <= fin + 1; c++) begin
      @(negedge clk);
      start_i = (c <= fin) ? 1'($urandom) : 1'b0;
      mask_i = NC'($urandom);
      noise = '0;
      if (noisy && launch[1] >= 0 && c >= launch[1] && c < launch[1] + lat[1]) begin
        noise[3] = 1'b1;
        if (c == launch[1]) noise[1] = 1'b1;
      end
      exp_start = '0;
      for (int k = 0; k < NC; k++) if (launch[k] == c) exp_start[k] = 1'b1;
      checks++;
      if (child_start_o !== exp_start) begin
        errors++;
        $display("FAIL child_start c=%0d got=%b exp=%b", c, child_start_o, exp_start);
      end
      checks++;
      if (done_o !== (c == fin)) begin
        errors++;
        $display("FAIL done c=%0d got=%b exp=%b", c, done_o, c == fin);
      end
      checks++;
      if (busy_o !== (c <= fin)) begin
        errors++;
        $display("FAIL busy c=%0d got=%b exp=%b", c, busy_o, c <= fin);
      end
      for (int k = 0; k < NC; k++) if (launch[k] == c || (c == fin + 1 && k == last_k)) begin
        checks++;
        if (cur_idx_o !== IW'(k)) begin
          errors++;
          $display("FAIL cur_idx c=%0d got=%0d exp=%0d", c, cur_idx_o, k);
        end
      end
      if (c == 1 || c == fin) begin
        checks++;
        if (fail_mask_o !== ((c == 1) ? '0 : exp_fail) || err_o !== ((c == 1) ? 1'b0 : |exp_fail)) begin
          errors++;
          $display("FAIL err_fail c=%0d got=%b/%b exp=%b/%b", c, err_o, fail_mask_o,
                   (c == 1) ? 1'b0 : |exp_fail, (c == 1) ? '0 : exp_fail);
        end
      end
    end
    noise = '0;
  endtask
  task automatic check_quiet(input string name);
    checks++;
    if ({busy_o, done_o, err_o, fail_mask_o, cur_idx_o, child_start_o} !== '0) begin
      errors++;
      $display("FAIL %s got=%b%b%b %b %0d %b exp=all zero", name, busy_o, done_o, err_o,
               fail_mask_o, cur_idx_o, child_start_o);
    end
  endtask
  task automatic test_reset;
    set_lat(4);
    repeat (3) @(negedge clk);
    check_quiet("reset_values");
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle_after_reset");
  endtask
  task automatic test_all_children;
    set_lat(4);
    run_seq(5'b11111, 1'b0);
  endtask
  task automatic test_sparse;
    for (int k = 0; k < NC; k++) lat[k] = $urandom_range(1, 6);
    run_seq(5'b10100, 1'b0);
  endtask
  task automatic test_empty;
    run_seq('0, 1'b0);
  endtask
  task automatic test_foreign_done;
    set_lat(3);
    lat[1] = 8;
    run_seq(5'b01010, 1'b1);
    run_seq(5'b11111, 1'b1);
  endtask
  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NC; k++) lat[k] = $urandom_range(1, 6);
      run_seq(NC'($urandom), 1'b0);
    end
  endtask
`ifdef CHILD_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    set_lat(3);
    lat[2] = 0;
    run_seq(5'b11111, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || fail_mask_o !== 5'b00100) begin
      errors++;
      $display("FAIL err_sticky got=%b/%b exp=1/00100", err_o, fail_mask_o);
    end
    lat[2] = 3;
    run_seq(5'b00110, 1'b0);
  endtask
`endif
  task automatic test_reset_mid_run;
    set_lat(4);
    lat[1] = 30;
    @(negedge clk);
    start_i = 1'b1;
    mask_i = 5'b11111;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_quiet("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_quiet("quiet_after_reset");
    end
    set_lat(4);
    run_seq(5'b11111, 1'b0);
  endtask
  initial begin
    test_reset;
    test_all_children;
    test_sparse;
    test_empty;
    test_foreign_done;
    test_random;
`ifdef CHILD_SEQ_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
